// File: rtl/plot_framebuffer_if.sv
// Plot request bus from the sprite datapaths plus the raster pixel stream to the display stage.
// Latency: none, wires only.
// Backpressure: plot is held by the source until plot_ready; the pixel stream has none.
interface plot_framebuffer_if;
   logic [7:0] x;
   logic [7:0] y;
   logic [2:0] colour;
   logic       plot;
   logic       plot_ready;
   logic       pixel_valid;
   logic [7:0] pixel_x;
   logic [7:0] pixel_y;
   logic [2:0] pixel_colour;
   logic       frame_start;

   // sprite/datapath side: issues plots, consumes the pixel stream
   modport master (
      output x, y, colour, plot,
      input  plot_ready, pixel_valid, pixel_x, pixel_y, pixel_colour, frame_start
   );

   // framebuffer side
   modport slave (
      input  x, y, colour, plot,
      output plot_ready, pixel_valid, pixel_x, pixel_y, pixel_colour, frame_start
   );
endinterface

// File: rtl/plot_framebuffer.sv
// Buffers plot writes in a small FIFO, commits them to a single-port framebuffer, scans it out in raster order.
// Latency: pixel appears one clock after its scan tick; a queued plot commits within DIV clocks once at the head.
// Backpressure: plot_ready drops while clearing or when the FIFO is full; held plots wait, out-of-range plots are dropped.
module plot_framebuffer #(
   parameter int         WIDTH  = 160,
   parameter int         HEIGHT = 120,
   parameter int         DIV    = 4,
   parameter int         DEPTH  = 4,
   parameter logic [2:0] BG     = 3'b000
) (
   input logic             clock,
   input logic             reset,
   plot_framebuffer_if.slave bus
);

   localparam int NPIX = WIDTH * HEIGHT;
   localparam int AW   = $clog2(NPIX);
   localparam int DW   = $clog2(DIV);
   localparam int PW   = $clog2(DEPTH);

   localparam logic [7:0]    X_LAST = 8'(WIDTH - 1);
   localparam logic [7:0]    Y_LAST = 8'(HEIGHT - 1);
   localparam logic [AW-1:0] A_LAST = AW'(NPIX - 1);
   localparam logic [DW-1:0] D_LAST = DW'(DIV - 1);
   localparam logic [PW:0]   F_FULL = (PW + 1)'(DEPTH);

   typedef enum logic {
      S_CLEAR = 1'b0,
      S_RUN   = 1'b1
   } state_t;

   state_t        state;
   state_t        state_nxt;
   logic          clearing;
   logic          running;
   logic [AW-1:0] clear_addr;

   logic [DW-1:0] divider;
   logic          pix_tick;
   logic [7:0]    scan_x;
   logic [7:0]    scan_y;
   logic [AW-1:0] scan_addr;

   logic [AW-1:0] fifo_addr [DEPTH];
   logic [2:0]    fifo_col  [DEPTH];
   logic [PW-1:0] wr_ptr;
   logic [PW-1:0] rd_ptr;
   logic [PW:0]   fifo_cnt;
   logic          fifo_full;
   logic          fifo_empty;
   logic          in_range;
   logic          push;
   logic          pop;
   logic [AW-1:0] plot_addr;

   logic [2:0]    mem [NPIX];
   logic          mem_we;
   logic [AW-1:0] mem_addr;
   logic [2:0]    mem_wdat;
   logic [2:0]    rd_dat;

   logic          pix_vld_q;
   logic [7:0]    pix_x_q;
   logic [7:0]    pix_y_q;
   logic          frame_start_q;

   // FSM state register: reset always restarts the clear sweep
   always_ff @(posedge clock or posedge reset) begin
      if (reset) state <= S_CLEAR;
      else       state <= state_nxt;
   end

   // FSM next state: leave CLEAR once the last address has been written
   always_comb begin
      state_nxt = state;
      case (state)
         S_CLEAR: if (clear_addr == A_LAST) state_nxt = S_RUN;
         S_RUN:   state_nxt = S_RUN;
         default: state_nxt = S_CLEAR;
      endcase
   end

   // FSM outputs: CLEAR owns the memory port, RUN enables scanout and commits
   always_comb begin
      clearing = 1'b0;
      running  = 1'b0;
      case (state)
         S_CLEAR: clearing = 1'b1;
         S_RUN:   running  = 1'b1;
         default: ;
      endcase
   end

   // clear sweep address, one location per cycle
   always_ff @(posedge clock or posedge reset) begin
      if (reset)                                clear_addr <= '0;
      else if (clearing && clear_addr != A_LAST) clear_addr <= clear_addr + 1'b1;
   end

   assign pix_tick  = running && (divider == D_LAST);
   assign scan_addr = AW'(scan_y) * AW'(WIDTH) + AW'(scan_x);

   // pixel clock divider and raster scan position
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         divider <= '0;
         scan_x  <= '0;
         scan_y  <= '0;
      end else if (running) begin
         divider <= (divider == D_LAST) ? '0 : divider + 1'b1;
         if (pix_tick) begin
            if (scan_x == X_LAST) begin
               scan_x <= '0;
               scan_y <= (scan_y == Y_LAST) ? '0 : scan_y + 1'b1;
            end else begin
               scan_x <= scan_x + 1'b1;
            end
         end
      end
   end

   // out-of-range plots complete the handshake but never enter the FIFO
   assign in_range   = (bus.x <= X_LAST) && (bus.y <= Y_LAST);
   assign fifo_empty = (fifo_cnt == '0);
   assign fifo_full  = (fifo_cnt == F_FULL);
   assign push       = bus.plot && bus.plot_ready && in_range;
   // scanout reads take the memory port on tick cycles, so commits wait one cycle
   assign pop        = running && !pix_tick && !fifo_empty;
   assign plot_addr  = AW'(bus.y) * AW'(WIDTH) + AW'(bus.x);

   // FIFO payload: precomputed address and colour
   always_ff @(posedge clock) begin
      if (push) begin
         fifo_addr[wr_ptr] <= plot_addr;
         fifo_col[wr_ptr]  <= bus.colour;
      end
   end

   // FIFO pointers and occupancy; simultaneous push and pop leaves the count unchanged
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         fifo_cnt <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({push, pop})
            2'b10:   fifo_cnt <= fifo_cnt + 1'b1;
            2'b01:   fifo_cnt <= fifo_cnt - 1'b1;
            default: fifo_cnt <= fifo_cnt;
         endcase
      end
   end

   // single memory port: clear write, commit write or scan read, never two at once
   assign mem_we   = clearing || pop;
   assign mem_addr = clearing ? clear_addr : (pop ? fifo_addr[rd_ptr] : scan_addr);
   assign mem_wdat = clearing ? BG : fifo_col[rd_ptr];

   // framebuffer write; contents survive reset
   always_ff @(posedge clock) begin
      if (mem_we) mem[mem_addr] <= mem_wdat;
   end

   // framebuffer read on the scan tick
   always_ff @(posedge clock or posedge reset) begin
      if (reset)         rd_dat <= '0;
      else if (pix_tick) rd_dat <= mem[mem_addr];
   end

   // pixel stream registers, aligned with the read data
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         pix_vld_q     <= 1'b0;
         pix_x_q       <= '0;
         pix_y_q       <= '0;
         frame_start_q <= 1'b0;
      end else begin
         pix_vld_q     <= pix_tick;
         frame_start_q <= pix_tick && (scan_x == '0) && (scan_y == '0);
         if (pix_tick) begin
            pix_x_q <= scan_x;
            pix_y_q <= scan_y;
         end
      end
   end

   assign bus.plot_ready   = running && !fifo_full;
   assign bus.pixel_valid  = pix_vld_q;
   assign bus.pixel_x      = pix_x_q;
   assign bus.pixel_y      = pix_y_q;
   assign bus.pixel_colour = rd_dat;
   assign bus.frame_start  = frame_start_q;

endmodule

// File: tb/tb_plot_framebuffer.sv
// Bench for plot_framebuffer: expected frames come from a reference image queued at stimulus time.
// Latency: frames are compared pixel by pixel as the DUT streams them.
// Backpressure: plots are held until plot_ready, with bounded waits.
module tb_plot_framebuffer;
   localparam int W  = 8;
   localparam int H  = 4;
   localparam int D  = 4;
   localparam int DP = 4;

   logic clock = 1'b0;
   logic reset = 1'b1;

   plot_framebuffer_if bus();

   plot_framebuffer #(
      .WIDTH (W),
      .HEIGHT(H),
      .DIV   (D),
      .DEPTH (DP),
      .BG    (3'b000)
   ) dut (
      .clock(clock),
      .reset(reset),
      .bus  (bus)
   );

   always #5 clock = ~clock;

   typedef struct packed {
      logic [7:0] px;
      logic [7:0] py;
      logic [2:0] pc;
      logic       fs;
   } pix_t;

   pix_t       exp_q[$];
   pix_t       obs[W*H];
   logic [2:0] model[W*H];
   logic [7:0] bx[8];
   logic [7:0] by[8];
   logic [2:0] bc[8];
   int         n_checks = 0;
   int         n_pass   = 0;

   // reference image -> expected frame, queued before the DUT produces it
   task automatic push_frame();
      for (int yy = 0; yy < H; yy++) begin
         for (int xx = 0; xx < W; xx++) begin
            pix_t e;
            e.px = 8'(xx);
            e.py = 8'(yy);
            e.pc = model[yy*W + xx];
            e.fs = (xx == 0 && yy == 0);
            exp_q.push_back(e);
         end
      end
   endtask

   task automatic next_pixel(output pix_t p, output bit ok);
      p  = '0;
      ok = 1'b0;
      for (int i = 0; i < 4*D + 4; i++) begin
         @(negedge clock);
         if (bus.pixel_valid === 1'b1) begin
            p  = {bus.pixel_x, bus.pixel_y, bus.pixel_colour, bus.frame_start};
            ok = 1'b1;
            break;
         end
      end
   endtask

   // capture one whole frame starting at the next frame_start
   task automatic collect_frame(output bit ok);
      pix_t p;
      bit   got;
      bit   found;
      found = 1'b0;
      p     = '0;
      for (int i = 0; i < 2*W*H + 2 && !found; i++) begin
         next_pixel(p, got);
         if (!got) break;
         if (p.fs === 1'b1) found = 1'b1;
      end
      ok     = found;
      obs[0] = p;
      for (int i = 1; i < W*H; i++) begin
         next_pixel(p, got);
         obs[i] = p;
         if (!got) ok = 1'b0;
      end
   endtask

   // hold plot high and step through bx/by/bc as each handshake completes
   task automatic plot_burst(input int n, output int acc);
      int cyc;
      acc = 0;
      cyc = 0;
      @(posedge clock); #1;
      bus.x = bx[0]; bus.y = by[0]; bus.colour = bc[0]; bus.plot = 1'b1;
      while (acc < n && cyc < 100) begin
         @(negedge clock);
         cyc++;
         if (bus.plot_ready === 1'b1) begin
            @(posedge clock); #1;
            acc++;
            if (acc < n) begin
               bus.x = bx[acc]; bus.y = by[acc]; bus.colour = bc[acc];
            end else begin
               bus.plot = 1'b0;
            end
         end
      end
      bus.plot = 1'b0;
   endtask

   task automatic test_reset();
      bit   ok;
      bit   seen_vld;
      pix_t e;
      reset = 1'b1;
      repeat (3) @(posedge clock);
      @(negedge clock);
      n_checks++;
      if ({bus.plot_ready, bus.pixel_valid, bus.pixel_x, bus.pixel_y, bus.pixel_colour, bus.frame_start} !== 22'd0)
         $display("FAIL reset_outputs got %h want 0", {bus.plot_ready, bus.pixel_valid, bus.pixel_x, bus.pixel_y, bus.pixel_colour, bus.frame_start});
      else n_pass++;
      reset    = 1'b0;
      seen_vld = 1'b0;
      repeat (31) begin
         @(negedge clock);
         if (bus.pixel_valid === 1'b1) seen_vld = 1'b1;
      end
      n_checks++;
      if (bus.plot_ready !== 1'b0) $display("FAIL clear_ready_low got %b want 0", bus.plot_ready);
      else n_pass++;
      n_checks++;
      if (seen_vld !== 1'b0) $display("FAIL clear_no_scan got %b want 0", seen_vld);
      else n_pass++;
      @(negedge clock);
      n_checks++;
      if (bus.plot_ready !== 1'b1) $display("FAIL clear_ready_rise got %b want 1", bus.plot_ready);
      else n_pass++;
      for (int i = 0; i < W*H; i++) model[i] = 3'b000;
      push_frame();
      collect_frame(ok);
      n_checks++;
      if (ok !== 1'b1) $display("FAIL reset_frame_sync got %b want 1", ok);
      else n_pass++;
      for (int i = 0; i < W*H; i++) begin
         e = exp_q.pop_front();
         n_checks++;
         if (obs[i] !== e) $display("FAIL reset_pix%0d got %h want %h", i, obs[i], e);
         else n_pass++;
      end
   endtask

   task automatic test_single_plot();
      bit   ok;
      int   acc;
      pix_t e;
      bx[0] = 8'd3; by[0] = 8'd2; bc[0] = 3'b101;
      plot_burst(1, acc);
      model[2*W + 3] = 3'b101;
      push_frame();
      n_checks++;
      if (acc !== 1) $display("FAIL single_accept got %0d want 1", acc);
      else n_pass++;
      repeat (20) @(posedge clock);
      collect_frame(ok);
      n_checks++;
      if (ok !== 1'b1) $display("FAIL single_frame_sync got %b want 1", ok);
      else n_pass++;
      for (int i = 0; i < W*H; i++) begin
         e = exp_q.pop_front();
         n_checks++;
         if (obs[i] !== e) $display("FAIL single_pix%0d got %h want %h", i, obs[i], e);
         else n_pass++;
      end
   endtask

   task automatic test_back_to_back();
      bit   ok;
      int   acc;
      pix_t e;
      bx[0] = 8'd0; by[0] = 8'd0; bc[0] = 3'b001;
      bx[1] = 8'd7; by[1] = 8'd0; bc[1] = 3'b010;
      bx[2] = 8'd5; by[2] = 8'd1; bc[2] = 3'b011;
      bx[3] = 8'd0; by[3] = 8'd3; bc[3] = 3'b100;
      bx[4] = 8'd7; by[4] = 8'd3; bc[4] = 3'b110;
      bx[5] = 8'd2; by[5] = 8'd2; bc[5] = 3'b111;
      plot_burst(6, acc);
      for (int i = 0; i < 6; i++) model[int'(by[i])*W + int'(bx[i])] = bc[i];
      push_frame();
      n_checks++;
      if (acc !== 6) $display("FAIL b2b_accepts got %0d want 6", acc);
      else n_pass++;
      repeat (30) @(posedge clock);
      collect_frame(ok);
      n_checks++;
      if (ok !== 1'b1) $display("FAIL b2b_frame_sync got %b want 1", ok);
      else n_pass++;
      for (int i = 0; i < W*H; i++) begin
         e = exp_q.pop_front();
         n_checks++;
         if (obs[i] !== e) $display("FAIL b2b_pix%0d got %h want %h", i, obs[i], e);
         else n_pass++;
      end
   endtask

   task automatic test_out_of_range();
      bit   ok;
      int   acc;
      pix_t e;
      bx[0] = 8'd9; by[0] = 8'd1; bc[0] = 3'b111;
      bx[1] = 8'd2; by[1] = 8'd7; bc[1] = 3'b111;
      plot_burst(2, acc);
      push_frame();
      n_checks++;
      if (acc !== 2) $display("FAIL oor_accepts got %0d want 2", acc);
      else n_pass++;
      repeat (20) @(posedge clock);
      collect_frame(ok);
      n_checks++;
      if (ok !== 1'b1) $display("FAIL oor_frame_sync got %b want 1", ok);
      else n_pass++;
      for (int i = 0; i < W*H; i++) begin
         e = exp_q.pop_front();
         n_checks++;
         if (obs[i] !== e) $display("FAIL oor_pix%0d got %h want %h", i, obs[i], e);
         else n_pass++;
      end
   endtask

   task automatic test_same_address();
      bit   ok;
      int   acc;
      pix_t e;
      bx[0] = 8'd1; by[0] = 8'd1; bc[0] = 3'b010;
      bx[1] = 8'd1; by[1] = 8'd1; bc[1] = 3'b100;
      plot_burst(2, acc);
      model[1*W + 1] = 3'b100;
      push_frame();
      n_checks++;
      if (acc !== 2) $display("FAIL waw_accepts got %0d want 2", acc);
      else n_pass++;
      repeat (20) @(posedge clock);
      collect_frame(ok);
      n_checks++;
      if (ok !== 1'b1) $display("FAIL waw_frame_sync got %b want 1", ok);
      else n_pass++;
      for (int i = 0; i < W*H; i++) begin
         e = exp_q.pop_front();
         n_checks++;
         if (obs[i] !== e) $display("FAIL waw_pix%0d got %h want %h", i, obs[i], e);
         else n_pass++;
      end
   endtask

   task automatic test_reset_mid_frame();
      bit   ok;
      bit   found;
      pix_t e;
      found = 1'b0;
      for (int i = 0; i < 400 && !found; i++) begin
         @(negedge clock);
         if (bus.pixel_valid === 1'b1 && bus.pixel_x === 8'd3 && bus.pixel_y === 8'd2) found = 1'b1;
      end
      n_checks++;
      if (found !== 1'b1) $display("FAIL midrst_find_pixel got %b want 1", found);
      else n_pass++;
      reset = 1'b1;
      #1;
      n_checks++;
      if ({bus.plot_ready, bus.pixel_valid, bus.pixel_x, bus.pixel_y, bus.pixel_colour, bus.frame_start} !== 22'd0)
         $display("FAIL midrst_outputs got %h want 0", {bus.plot_ready, bus.pixel_valid, bus.pixel_x, bus.pixel_y, bus.pixel_colour, bus.frame_start});
      else n_pass++;
      repeat (2) @(posedge clock);
      @(negedge clock);
      reset = 1'b0;
      repeat (31) @(negedge clock);
      n_checks++;
      if (bus.plot_ready !== 1'b0) $display("FAIL midrst_clear_low got %b want 0", bus.plot_ready);
      else n_pass++;
      @(negedge clock);
      n_checks++;
      if (bus.plot_ready !== 1'b1) $display("FAIL midrst_ready_rise got %b want 1", bus.plot_ready);
      else n_pass++;
      for (int i = 0; i < W*H; i++) model[i] = 3'b000;
      push_frame();
      collect_frame(ok);
      n_checks++;
      if (ok !== 1'b1) $display("FAIL midrst_frame_sync got %b want 1", ok);
      else n_pass++;
      for (int i = 0; i < W*H; i++) begin
         e = exp_q.pop_front();
         n_checks++;
         if (obs[i] !== e) $display("FAIL midrst_pix%0d got %h want %h", i, obs[i], e);
         else n_pass++;
      end
   endtask

   initial begin
      bus.x      = '0;
      bus.y      = '0;
      bus.colour = '0;
      bus.plot   = 1'b0;
      test_reset();
      test_single_plot();
      test_back_to_back();
      test_out_of_range();
      test_same_address();
      test_reset_mid_frame();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog got timeout want finish");
      $fatal(1);
   end

endmodule
